// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state types and opcode decode for the SPI command sequencer.
package spi_cmd_pkg;

   localparam logic [7:0] OP_NOP      = 8'h00;
   localparam logic [7:0] OP_SET_ADDR = 8'h10;
   localparam logic [7:0] OP_WRITE    = 8'h20;
   localparam logic [7:0] OP_READ     = 8'h30;
   localparam logic [7:0] OP_SET_MODE = 8'h40;

   typedef enum logic [2:0] {
      IDLE, ADDR0, ADDR1, ADDR2, WRITE, READ, MODE, IGNORE
   } cmd_state_e;

   typedef enum logic {
      MIDLE, MBUSY
   } mem_state_e;

   function automatic cmd_state_e decode_op(input logic [7:0] op);
      case (op)
         OP_NOP:      return IDLE;
         OP_SET_ADDR: return ADDR0;
         OP_WRITE:    return WRITE;
         OP_READ:     return READ;
         OP_SET_MODE: return MODE;
         default:     return IGNORE;
      endcase
   endfunction

endpackage

// File: rtl/spi_mem_port.sv
// Single-outstanding req/ack memory port with auto-incrementing address pointer
// and read-data capture into the MISO byte.
module spi_mem_port
   import spi_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_issue,
   input  logic              i_issue_we,
   input  logic [7:0]        i_issue_wdata,
   input  logic [2:0]        i_addr_ld,
   input  logic [7:0]        i_addr_byte,
   input  logic              i_rd_discard,
   input  logic              i_mem_ack,
   input  logic [7:0]        i_mem_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_mem_we,
   output logic              o_mem_req,
   output logic              o_busy,
   output logic [7:0]        o_spi_tx_data,
   output logic              o_ack_c
);

   localparam int unsigned PW = (ADDR_W > 24) ? ADDR_W : 24;

   mem_state_e        r_mstate, w_mstate_nxt;
   logic [ADDR_W-1:0] r_ptr, w_ptr_nxt, r_addr;
   logic [PW-1:0]     w_ld;
   logic              r_we, r_rd_keep, w_ack;
   logic [7:0]        r_wdata, r_tx;

   // Acks are only meaningful while a request is outstanding
   assign w_ack = i_mem_ack && (r_mstate == MBUSY);

   // Byte loads take priority over the post-ack increment
   always_comb begin
      w_ld = PW'(r_ptr);
      if (i_addr_ld[2]) w_ld[23:16] = i_addr_byte;
      if (i_addr_ld[1]) w_ld[15:8]  = i_addr_byte;
      if (i_addr_ld[0]) w_ld[7:0]   = i_addr_byte;
      w_ptr_nxt = r_ptr;
      if (|i_addr_ld)  w_ptr_nxt = ADDR_W'(w_ld);
      else if (w_ack)  w_ptr_nxt = r_ptr + ADDR_W'(1);
   end

   always_comb begin
      w_mstate_nxt = r_mstate;
      case (r_mstate)
         MIDLE:   if (i_issue) w_mstate_nxt = MBUSY;
         MBUSY:   if (w_ack)   w_mstate_nxt = i_issue ? MBUSY : MIDLE;
         default: w_mstate_nxt = MIDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mstate  <= MIDLE;
         r_ptr     <= '0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= 8'h00;
         r_rd_keep <= 1'b0;
         r_tx      <= 8'h00;
      end else begin
         r_mstate <= w_mstate_nxt;
         r_ptr    <= w_ptr_nxt;
         if (i_issue) begin
            r_addr    <= w_ptr_nxt;
            r_we      <= i_issue_we;
            r_rd_keep <= !i_issue_we;
            if (i_issue_we) r_wdata <= i_issue_wdata;
         end else if (i_rd_discard) begin
            r_rd_keep <= 1'b0;
         end
         if (w_ack && !r_we && r_rd_keep && !i_rd_discard) r_tx <= i_mem_rdata;
      end
   end

   assign o_mem_addr    = r_addr;
   assign o_mem_wdata   = r_wdata;
   assign o_mem_we      = r_we;
   assign o_mem_req     = (r_mstate == MBUSY);
   assign o_busy        = (r_mstate == MBUSY);
   assign o_spi_tx_data = r_tx;
   assign o_ack_c       = w_ack;

endmodule

// File: rtl/spi_cmd_seq.sv
// SPI command sequencer: decodes opcode/parameter strobes into address, mode
// and single-byte memory requests.
module spi_cmd_seq
   import spi_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_ready,
   input  logic              param_ready,
   input  logic [7:0]        cmd_data,
   input  logic [7:0]        param_data,
   output logic [7:0]        spi_tx_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        mode,
   output logic              busy,
   output logic              overrun
);

   cmd_state_e r_state, w_state_nxt;
   logic [7:0] r_mode;
   logic       r_overrun, r_rd_pend, w_rd_pend_nxt;
   logic       w_issue, w_issue_we, w_mode_ld, w_ovr_set, w_rd_discard;
   logic [2:0] w_addr_ld;
   logic       w_busy, w_ack, w_can_issue;

   assign w_can_issue = !w_busy || w_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mode    <= 8'h00;
         r_overrun <= 1'b0;
         r_rd_pend <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= w_rd_pend_nxt;
         if (w_mode_ld) r_mode <= param_data;
         if (cmd_ready)      r_overrun <= 1'b0;
         else if (w_ovr_set) r_overrun <= 1'b1;
      end
   end

   // A READ arriving while busy is parked in r_rd_pend and fetched once the port frees
   always_comb begin
      w_state_nxt   = r_state;
      w_issue       = 1'b0;
      w_issue_we    = 1'b0;
      w_addr_ld     = 3'b000;
      w_mode_ld     = 1'b0;
      w_ovr_set     = 1'b0;
      w_rd_discard  = 1'b0;
      w_rd_pend_nxt = r_rd_pend;
      if (cmd_ready) begin
         w_state_nxt   = decode_op(cmd_data);
         w_rd_discard  = (cmd_data != OP_READ);
         w_rd_pend_nxt = 1'b0;
         if (cmd_data == OP_READ) begin
            if (w_busy) w_rd_pend_nxt = 1'b1;
            else        w_issue       = 1'b1;
         end
      end else if (r_rd_pend) begin
         if (!w_busy) begin
            w_issue       = 1'b1;
            w_rd_pend_nxt = 1'b0;
         end
         if (param_ready) w_ovr_set = 1'b1;
      end else if (param_ready) begin
         case (r_state)
            ADDR0: begin w_addr_ld = 3'b100; w_state_nxt = ADDR1; end
            ADDR1: begin w_addr_ld = 3'b010; w_state_nxt = ADDR2; end
            ADDR2: begin w_addr_ld = 3'b001; w_state_nxt = IDLE;  end
            MODE:  begin w_mode_ld = 1'b1;   w_state_nxt = IDLE;  end
            WRITE, READ: begin
               if (w_can_issue) begin
                  w_issue    = 1'b1;
                  w_issue_we = (r_state == WRITE);
               end else begin
                  w_ovr_set  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   spi_mem_port #(.ADDR_W(ADDR_W)) u_mem_port (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_issue       (w_issue),
      .i_issue_we    (w_issue_we),
      .i_issue_wdata (param_data),
      .i_addr_ld     (w_addr_ld),
      .i_addr_byte   (param_data),
      .i_rd_discard  (w_rd_discard),
      .i_mem_ack     (mem_ack),
      .i_mem_rdata   (mem_rdata),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .o_mem_we      (mem_we),
      .o_mem_req     (mem_req),
      .o_busy        (w_busy),
      .o_spi_tx_data (spi_tx_data),
      .o_ack_c       (w_ack)
   );

   assign mode    = r_mode;
   assign busy    = w_busy;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Scoreboard bench for spi_cmd_seq: a message-level model predicts memory
// requests and register values; a memory responder pops and compares requests.
module tb_spi_cmd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_ready = 1'b0, param_ready = 1'b0;
   logic [7:0]  cmd_data = 8'h00, param_data = 8'h00;
   logic [7:0]  spi_tx_data, mem_wdata, mode;
   logic [23:0] mem_addr;
   logic        mem_we, mem_req, busy, overrun;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;

   typedef struct packed {
      logic [23:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } req_t;

   typedef enum {M_IDLE, M_A0, M_A1, M_A2, M_WR, M_RD, M_MODE, M_IGN} mstate_t;

   req_t        exp_q[$];
   int          n_chk = 0, n_fail = 0;
   int          ack_lat = 0;
   logic [23:0] m_ptr = 24'h0;
   logic [7:0]  m_mode = 8'h00, m_tx = 8'h00;
   mstate_t     m_st = M_IDLE;

   spi_cmd_seq #(.ADDR_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready), .param_ready(param_ready),
      .cmd_data(cmd_data), .param_data(param_data), .spi_tx_data(spi_tx_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mode(mode), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_read(input logic [7:0] rd);
      req_t e;
      e.addr = m_ptr; e.we = 1'b0; e.wdata = 8'h00; e.rdata = rd;
      exp_q.push_back(e);
      m_tx = rd;
      m_ptr = m_ptr + 24'd1;
   endtask

   task automatic exp_write(input logic [7:0] d);
      req_t e;
      e.addr = m_ptr; e.we = 1'b1; e.wdata = d; e.rdata = 8'($urandom);
      exp_q.push_back(e);
      m_ptr = m_ptr + 24'd1;
   endtask

   task automatic drive_cmd(input logic [7:0] op);
      @(negedge clk);
      cmd_data = op; cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic drive_param(input logic [7:0] p);
      @(negedge clk);
      param_data = p; param_ready = 1'b1;
      @(negedge clk);
      param_ready = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] op, input logic [7:0] rd, input int gap);
      case (op)
         8'h00:   m_st = M_IDLE;
         8'h10:   m_st = M_A0;
         8'h20:   m_st = M_WR;
         8'h30:   begin m_st = M_RD; exp_read(rd); end
         8'h40:   m_st = M_MODE;
         default: m_st = M_IGN;
      endcase
      drive_cmd(op);
      repeat (gap) @(negedge clk);
   endtask

   task automatic param(input logic [7:0] p, input logic [7:0] rd, input int gap);
      case (m_st)
         M_A0:   begin m_ptr[23:16] = p; m_st = M_A1; end
         M_A1:   begin m_ptr[15:8]  = p; m_st = M_A2; end
         M_A2:   begin m_ptr[7:0]   = p; m_st = M_IDLE; end
         M_MODE: begin m_mode = p; m_st = M_IDLE; end
         M_WR:   exp_write(p);
         M_RD:   exp_read(rd);
         default: ;
      endcase
      drive_param(p);
      repeat (gap) @(negedge clk);
   endtask

   // Memory responder and request monitor
   initial begin
      req_t e;
      int   lat;
      @(negedge clk);
      forever begin
         while (!(rst_n === 1'b1 && mem_req === 1'b1)) @(negedge clk);
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_req: addr %h we %b with no request expected", mem_addr, mem_we);
            e = '0;
         end else begin
            e = exp_q.pop_front();
            chk("req_addr", 32'(mem_addr), 32'(e.addr));
            chk("req_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("req_wdata", 32'(mem_wdata), 32'(e.wdata));
         end
         lat = (ack_lat > 0) ? ack_lat : int'($urandom_range(1, 8));
         repeat (lat - 1) @(negedge clk);
         mem_ack = 1'b1; mem_rdata = e.rdata;
         @(negedge clk);
         mem_ack = 1'b0;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx"},    32'(spi_tx_data), 32'h0);
      chk({tag, "_addr"},  32'(mem_addr), 32'h0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, "_we"},    32'(mem_we), 32'h0);
      chk({tag, "_req"},   32'(mem_req), 32'h0);
      chk({tag, "_mode"},  32'(mode), 32'h0);
      chk({tag, "_busy"},  32'(busy), 32'h0);
      chk({tag, "_ovr"},   32'(overrun), 32'h0);
   endtask

   initial begin
      logic [7:0] op_tab [6];
      op_tab[0] = 8'h00; op_tab[1] = 8'h10; op_tab[2] = 8'h20;
      op_tab[3] = 8'h30; op_tab[4] = 8'h40; op_tab[5] = 8'h7E;

      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Address load and write burst with short ack latency
      ack_lat = 2;
      cmd(8'h10, 8'h00, 12);
      param(8'h12, 8'h00, 12); param(8'h34, 8'h00, 12); param(8'h56, 8'h00, 12);
      cmd(8'h20, 8'h00, 12);
      param(8'hAA, 8'h00, 12); param(8'hBB, 8'h00, 12);
      cmd(8'h30, 8'hC1, 12);
      chk("burst_tx", 32'(spi_tx_data), 32'(m_tx));

      // Read at the top of the address space wraps to zero
      cmd(8'h10, 8'h00, 12);
      param(8'hFF, 8'h00, 12); param(8'hFF, 8'h00, 12); param(8'hFF, 8'h00, 12);
      cmd(8'h30, 8'h5C, 12);
      chk("wrap_tx", 32'(spi_tx_data), 32'h5C);
      param(8'h00, 8'h3A, 12);
      chk("wrap_tx2", 32'(spi_tx_data), 32'h3A);

      // Second write arrives while the first is still outstanding
      ack_lat = 20;
      cmd(8'h20, 8'h00, 12);
      param(8'h33, 8'h00, 0);
      repeat (9) @(negedge clk);
      drive_param(8'h44);
      chk("ovr_set", 32'(overrun), 32'h1);
      repeat (25) @(negedge clk);
      chk("ovr_sticky", 32'(overrun), 32'h1);
      chk("ovr_idle", 32'(busy), 32'h0);
      cmd(8'h00, 8'h00, 2);
      chk("ovr_clear", 32'(overrun), 32'h0);

      // Ack lands in the same cycle as the next write parameter
      ack_lat = 5;
      cmd(8'h20, 8'h00, 12);
      param(8'h11, 8'h00, 0);
      repeat (3) @(negedge clk);
      param(8'h22, 8'h00, 0);
      chk("coinc_req", 32'(mem_req), 32'h1);
      chk("coinc_ovr", 32'(overrun), 32'h0);
      repeat (12) @(negedge clk);

      // New command while a read is outstanding discards its data
      ack_lat = 20;
      exp_q.push_back('{addr: m_ptr, we: 1'b0, wdata: 8'h00, rdata: 8'hE7});
      m_ptr = m_ptr + 24'd1;
      m_st = M_RD;
      drive_cmd(8'h30);
      repeat (5) @(negedge clk);
      cmd(8'h00, 8'h00, 25);
      chk("discard_tx", 32'(spi_tx_data), 32'(m_tx));

      // Mode register and ignored opcode
      ack_lat = 0;
      cmd(8'h40, 8'h00, 12);
      param(8'h03, 8'h00, 12);
      chk("mode_set", 32'(mode), 32'h03);
      cmd(8'h7E, 8'h00, 12);
      for (int i = 0; i < 5; i++) param(8'($urandom), 8'h00, 12);
      chk("ign_mode", 32'(mode), 32'h03);
      chk("ign_req", 32'(mem_req), 32'h0);
      cmd(8'h30, 8'h9D, 12);
      chk("ign_tx", 32'(spi_tx_data), 32'h9D);

      // Reset while a write is outstanding
      ack_lat = 30;
      cmd(8'h20, 8'h00, 12);
      param(8'h99, 8'h00, 0);
      repeat (4) @(negedge clk);
      chk("pre_rst_req", 32'(mem_req), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      m_ptr = 24'h0; m_mode = 8'h00; m_tx = 8'h00; m_st = M_IDLE;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_req", 32'(mem_req), 32'h0);

      // Randomized message stream
      ack_lat = 0;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0)
            cmd(op_tab[$urandom_range(0, 5)], 8'($urandom), 12);
         else
            param(8'($urandom), 8'($urandom), 12);
         chk("rnd_tx", 32'(spi_tx_data), 32'(m_tx));
         chk("rnd_mode", 32'(mode), 32'(m_mode));
         chk("rnd_ovr", 32'(overrun), 32'h0);
      end

      repeat (20) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_cmd_seq.md
# spi_cmd_seq

Command sequencer between the SPI slave receiver and the on-board memory bus. It consumes the receiver's per-byte `cmd_ready`/`param_ready` strobes and decodes opcodes. It keeps an auto-incrementing address pointer, issues single-byte read and write requests over a req/ack memory port, and supplies the byte the receiver shifts out on MISO. It also holds a mode register for the rest of the design.

## Interface
- `ADDR_W`, 24: memory address width. SET_ADDR bits above `ADDR_W-1` are discarded.
- `clk`  in  1  system clock; same clock as the SPI receiver's `clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_ready`  in  1  one-cycle strobe; `cmd_data` holds the first byte of a message.
- `param_ready`  in  1  one-cycle strobe; `param_data` holds a subsequent byte of the message.
- `cmd_data`  in  8  opcode byte.
- `param_data`  in  8  parameter byte.
- `spi_tx_data`  out  8  byte presented to the receiver's `input_data` (MISO source).
- `mem_addr`  out  ADDR_W  request address.
- `mem_wdata`  out  8  write data.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_req`  out  1  request; held high until `mem_ack`.
- `mem_ack`  in  1  one-cycle completion; `mem_rdata` is valid in the same cycle for reads.
- `mem_rdata`  in  8  read data.
- `mode`  out  8  mode register.
- `busy`  out  1  high while a memory request is outstanding.
- `overrun`  out  1  sticky; a parameter byte arrived while `busy` and was dropped. Cleared by the next `cmd_ready`.

## Operation
- Opcodes, on `cmd_ready`:
  - 0x00 NOP.
  - 0x10 SET_ADDR: 3 params, MSB first.
  - 0x20 WRITE: each param is one byte written.
  - 0x30 READ: prefetch; each param is a dummy byte that triggers the next read.
  - 0x40 SET_MODE: 1 param.
  - Any other opcode is IGNORE.
- Command FSM states: IDLE, ADDR0, ADDR1, ADDR2, WRITE, READ, MODE, IGNORE.
  - `cmd_ready` in any state re-decodes the opcode and enters the matching state (NOP→IDLE, unknown→IGNORE).
  - ADDR0→ADDR1→ADDR2 advance on each `param_ready`, loading addr[23:16], [15:8], [7:0] in turn. ADDR2's param→IDLE.
  - MODE: a param loads `mode` and goes to IDLE.
  - WRITE and READ stay in their state until the next `cmd_ready`.
  - IDLE and IGNORE drop params silently; they do not set overrun.
- Memory port states: MIDLE and MBUSY.
  - An issue moves MIDLE→MBUSY; `mem_ack` moves MBUSY→MIDLE.
  - `mem_addr`, `mem_we` and `mem_wdata` are stable for the whole MBUSY interval.
- WRITE: each param issues a write of `param_data` to the address pointer.
- READ: `cmd_ready` itself issues a read at the pointer. Each param issues the next read.
- On `mem_ack` of any request, the address pointer increments, wrapping modulo 2^ADDR_W. On `mem_ack` of a read, the read data is loaded into `spi_tx_data`.
- A param in WRITE or READ while MBUSY (and no `mem_ack` that cycle) is dropped and sets `overrun`.
- A new `cmd_ready` while MBUSY:
  - The outstanding request completes normally and the address still increments.
  - Its read data is discarded if the new opcode is not READ.
  - A new READ's initial fetch is issued the cycle after the ack.
- SET_ADDR while MBUSY: parameter loads override the post-ack increment when both happen in the same cycle.

## Timing
- Reset values: `spi_tx_data`=0x00, `mem_addr`=0, `mem_wdata`=0x00, `mem_we`=0, `mem_req`=0, `mode`=0x00, `busy`=0, `overrun`=0, FSM=IDLE/MIDLE.
- Strobe in cycle N → `mem_req` high in N+1; all outputs are registered.
- `mem_ack` in cycle M → in M+1: `mem_req` low, pointer+1, `spi_tx_data` updated (reads).
- `mem_ack` and an accepted param in the same cycle: the param is not an overrun. `mem_req` stays high in M+1 with the new, incremented address.
- Strobes are at least 8 SCK periods apart; any memory latency shorter than that never overruns.

## Structure
- Shared package `spi_cmd_pkg`: opcode constants (OP_NOP, OP_SET_ADDR, OP_WRITE, OP_READ, OP_SET_MODE) and the command/memory FSM state enums.
- One sub-module, `spi_mem_port`: the req/ack holder, the address pointer with load/increment, and read-data capture. The top module holds the command FSM, `mode` and `overrun`.

## Test plan
- Reset mid-write (`mem_req`=1): assert `rst_n`=0 → all outputs take their reset values immediately; no ack is required afterwards.
- SET_ADDR 0x12,0x34,0x56 then WRITE 0xAA,0xBB, ack latency 2 → writes to 0x123456/0x123457; pointer ends at 0x123458.
- SET_ADDR 0xFF,0xFF,0xFF, then READ with `mem_rdata`=0x5C → `spi_tx_data`=0x5C; pointer wraps to 0x000000.
- WRITE with ack latency 20 and a second param at latency 10 → second byte dropped, `overrun`=1; next `cmd_ready` clears it.
- Ack coincides with a param → `mem_req` stays high; address advances by 1; `overrun`=0.
- SET_MODE 0x03 → `mode`=0x03. Opcode 0x7E followed by 5 params → no `mem_req`; `mode` and pointer unchanged.
